// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for a PWM duty input. Steps are applied only on PWM period boundaries.
// Optional breathe mode (endless ramp between target and 0) is enabled with PWM_FADE_BREATHE_EN.
module pwm_fade_ctrl #(
    parameter int DUTY_W     = 8,
    parameter int DUTY_MAX   = 100,
    parameter int INTERVAL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  period_end,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DUTY_W-1:0]     cmd_target,
    input  logic [DUTY_W-1:0]     cmd_step,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic                  abort,
`ifdef PWM_FADE_BREATHE_EN
    input  logic                  cmd_loop,
`endif
    output logic [DUTY_W-1:0]     duty,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RAMP, FINISH} state_t;

    localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);

    state_t                state_q, state_d;
    logic [DUTY_W-1:0]     duty_q;
    logic [DUTY_W-1:0]     goal_q;
    logic [DUTY_W-1:0]     step_q;
    logic [INTERVAL_W-1:0] interval_q;
    logic [INTERVAL_W-1:0] count_q;
`ifdef PWM_FADE_BREATHE_EN
    logic [DUTY_W-1:0]     target_q;
    logic                  loop_q;
`endif

    logic                  accept;
    logic                  loop_active;
    logic [DUTY_W-1:0]     target_c;
    logic [DUTY_W-1:0]     step_c;
    logic [INTERVAL_W-1:0] interval_c;
    logic [INTERVAL_W:0]   count_inc;
    logic                  interval_hit;
    logic                  step_take;
    logic                  going_up;
    logic [DUTY_W:0]       diff;
    logic [DUTY_W-1:0]     delta;
    logic [DUTY_W-1:0]     next_duty;
    logic                  reach;

    assign accept = cmd_valid && cmd_ready;

`ifdef PWM_FADE_BREATHE_EN
    assign loop_active = loop_q;
`else
    assign loop_active = 1'b0;
`endif

    // Command fields are normalised once at accept so the ramp logic never sees illegal values
    assign target_c   = (cmd_target > DUTY_MAX_V) ? DUTY_MAX_V : cmd_target;
    assign step_c     = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;
    assign interval_c = (cmd_interval == '0) ? INTERVAL_W'(1) : cmd_interval;

    assign count_inc    = {1'b0, count_q} + 1'b1;
    assign interval_hit = count_inc >= {1'b0, interval_q};
    assign step_take    = (state_q == RAMP) && !abort && period_end && interval_hit;

    // Distance is taken one bit wider and the step is capped to it, so the ramp never overshoots
    assign going_up  = goal_q >= duty_q;
    assign diff      = going_up ? ({1'b0, goal_q} - {1'b0, duty_q})
                                : ({1'b0, duty_q} - {1'b0, goal_q});
    assign delta     = ({1'b0, step_q} < diff) ? step_q : diff[DUTY_W-1:0];
    assign next_duty = going_up ? (duty_q + delta) : (duty_q - delta);
    assign reach     = step_take && (next_duty == goal_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (target_c == duty_q) ? FINISH : RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (reach && !loop_active) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An abort landing on the FINISH cycle suppresses the done pulse
    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q == RAMP);
        done      = (state_q == FINISH) && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q     <= '0;
            goal_q     <= '0;
            step_q     <= DUTY_W'(1);
            interval_q <= INTERVAL_W'(1);
            count_q    <= '0;
`ifdef PWM_FADE_BREATHE_EN
            target_q   <= '0;
            loop_q     <= 1'b0;
`endif
        end else if (accept) begin
            goal_q     <= target_c;
            step_q     <= step_c;
            interval_q <= interval_c;
            count_q    <= '0;
`ifdef PWM_FADE_BREATHE_EN
            target_q   <= target_c;
            loop_q     <= cmd_loop;
`endif
        end else if (state_q == RAMP) begin
            if (abort) begin
                count_q <= '0;
            end else if (period_end) begin
                if (interval_hit) begin
                    count_q <= '0;
                    duty_q  <= next_duty;
`ifdef PWM_FADE_BREATHE_EN
                    if (reach && loop_q) begin
                        goal_q <= (goal_q == target_q) ? '0 : target_q;
                    end
`endif
                end else begin
                    count_q <= count_inc[INTERVAL_W-1:0];
                end
            end
        end
    end

    assign duty = duty_q;

endmodule
